// File: rtl/decimal_fft_streamer.sv
// Captures one 8-bin FFT result frame (real/imag whole, frac, flag per bin) and streams it
// out as 16 words R0,I0,...,R7,I7 over a valid/ready handshake.
module decimal_fft_streamer #(
    parameter int NPTS = 8,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_valid,
    input  logic [NPTS*W-1:0] rwhole_bus,
    input  logic [NPTS*W-1:0] rfrac_bus,
    input  logic [NPTS-1:0]   rflag_bus,
    input  logic [NPTS*W-1:0] iwhole_bus,
    input  logic [NPTS*W-1:0] ifrac_bus,
    input  logic [NPTS-1:0]   iflag_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_whole,
    output logic [W-1:0]      out_frac,
    output logic              out_flag,
    output logic              out_is_imag,
    output logic [2:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int IW = $clog2(NPTS);
    localparam int KW = IW + 1;
    localparam logic [KW-1:0] KLAST = KW'(2 * NPTS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [NPTS*W-1:0]   rwhole_q, rfrac_q, iwhole_q, ifrac_q;
    logic [NPTS-1:0]     rflag_q, iflag_q;
    logic [7:0]          drop_cnt_q;
    logic                load;
    logic                drop;
    logic [IW-1:0]       idx;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    load    = 1'b1;
                    k_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (k_q == KLAST) begin
                        k_d = '0;
                        // A capture landing on the final accept chains straight into the next frame.
                        if (cap_valid) load = 1'b1;
                        else           state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                drop = cap_valid && !(out_ready && (k_q == KLAST));
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the frame registers are reset too, because the outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rwhole_q <= '0;
            rfrac_q  <= '0;
            rflag_q  <= '0;
            iwhole_q <= '0;
            ifrac_q  <= '0;
            iflag_q  <= '0;
        end else if (load) begin
            rwhole_q <= rwhole_bus;
            rfrac_q  <= rfrac_bus;
            rflag_q  <= rflag_bus;
            iwhole_q <= iwhole_bus;
            ifrac_q  <= ifrac_bus;
            iflag_q  <= iflag_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // Fields are passed through untouched; k[0] picks real/imag, k[KW-1:1] picks the bin.
    always_comb begin
        idx         = k_q[KW-1:1];
        out_valid   = (state_q == SEND);
        busy        = out_valid;
        out_last    = out_valid && (k_q == KLAST);
        out_is_imag = k_q[0];
        out_index   = 3'(idx);
        drop_cnt    = drop_cnt_q;
        if (k_q[0]) begin
            out_whole = iwhole_q[idx*W +: W];
            out_frac  = ifrac_q[idx*W +: W];
            out_flag  = iflag_q[idx];
        end else begin
            out_whole = rwhole_q[idx*W +: W];
            out_frac  = rfrac_q[idx*W +: W];
            out_flag  = rflag_q[idx];
        end
    end

endmodule

// File: doc/decimal_fft_streamer.md
DECIMAL_FFT_STREAMER -- requirements
Module: decimal_fft_streamer

Interface
REQ-001 Parameter: NPTS, 8, number of FFT bins per frame; only 8 is supported.
REQ-002 Parameter: W, 16, width of each whole and frac field.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: cap_valid  input  1  one-cycle strobe; all FFT result buses are stable this cycle.
REQ-006 Port: rwhole_bus  input  128  signed real whole parts, bin k at [16k+15:16k].
REQ-007 Port: rfrac_bus  input  128  real fraction fields, same packing.
REQ-008 Port: rflag_bus  input  8  real sign flags, bit k is bin k; a set flag with whole==0 means negative.
REQ-009 Port: iwhole_bus  input  128  signed imaginary whole parts, same packing.
REQ-010 Port: ifrac_bus  input  128  imaginary fraction fields, same packing.
REQ-011 Port: iflag_bus  input  8  imaginary sign flags, same packing.
REQ-012 Port: out_valid  output  1  current output word is valid.
REQ-013 Port: out_ready  input  1  consumer accepts the word when it is high together with out_valid.
REQ-014 Port: out_whole  output  16  signed whole part of the current word.
REQ-015 Port: out_frac  output  16  fraction of the current word.
REQ-016 Port: out_flag  output  1  sign flag of the current word.
REQ-017 Port: out_is_imag  output  1  0 = real word, 1 = imaginary word.
REQ-018 Port: out_index  output  3  bin number 0..7 of the current word.
REQ-019 Port: out_last  output  1  high on the 16th word of the frame.
REQ-020 Port: busy  output  1  a frame is held or in transfer.
REQ-021 Port: drop_cnt  output  8  saturating count of rejected capture strobes.

Function
REQ-022 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-023 In IDLE, cap_valid=1 SHALL latch all six buses into internal frame registers, clear the word counter k (4 bits) and enter SEND on the same edge.
REQ-024 out_valid SHALL be 1 exactly when the state is SEND; busy SHALL equal out_valid.
REQ-025 Latency: cap_valid sampled high at edge N SHALL give out_valid=1 with word 0 in the cycle after edge N.
REQ-026 Word order SHALL be R0,I0,R1,I1,...,R7,I7: out_index=k[3:1], out_is_imag=k[0], out_last=(k==15).
REQ-027 out_whole, out_frac and out_flag SHALL be the latched fields of the selected bin and part, passed through bit-exact with no arithmetic, normalisation or sign folding.
REQ-028 While out_valid=1 and out_ready=0, all output fields SHALL remain stable.
REQ-029 In SEND, out_valid&out_ready SHALL advance k by 1, at most one word per cycle.
REQ-030 An accept at k==15 SHALL return the FSM to IDLE and clear k.
REQ-031 cap_valid in SEND SHALL be ignored, frame registers SHALL be unchanged, and drop_cnt SHALL increment, saturating at 255.
REQ-032 cap_valid in the same cycle as the accept at k==15 SHALL NOT be a drop: the new frame SHALL be latched, k set to 0, and the FSM SHALL stay in SEND with no idle gap.
REQ-033 out_ready while in IDLE SHALL have no effect.
REQ-034 Throughput: with out_ready held at 1, one frame SHALL take exactly 16 cycles of out_valid.

Reset
REQ-035 rst=0 SHALL, immediately and asynchronously, force: state IDLE, k=0, all frame registers 0, out_valid=0, busy=0, out_last=0, drop_cnt=0, and out_whole/out_frac/out_flag/out_is_imag/out_index all 0.
REQ-036 Reset asserted during SEND SHALL abort the frame with no further words emitted; after release the block SHALL wait for a new cap_valid.
REQ-037 The first cap_valid honoured SHALL be the one sampled at the first rising edge after rst returns to 1.

Verification
REQ-038 Basic frame: bin0 real = whole 32, frac 20, flag 0; bin2 real = whole 0, frac 20, flag 1; other bins distinct; out_ready=1 -> 16 words in order R0..I7 on consecutive cycles, word 4 (R2) = 0/20/1, out_last only on word 15.
REQ-039 Backpressure: toggle out_ready with a pseudo-random pattern -> fields stable while stalled, no word lost or repeated, same 16-word sequence as the basic frame.
REQ-040 Drop: cap_valid pulsed at words 3 and 9 of a frame -> drop_cnt=2 and the frame continues with the original data; 300 drops -> drop_cnt=255.
REQ-041 Back-to-back: cap_valid coincides with the accept of I7 -> next cycle shows word 0 of the new frame, out_valid stays 1, drop_cnt unchanged.
REQ-042 Reset mid-frame: rst=0 at word 6 -> out_valid=0 and drop_cnt=0 immediately; after release no output until the next cap_valid, then a full frame from R0.
REQ-043 Negative values: bin4 real whole = -32, frac 10, flag 0 -> R4 emitted as 0xFFE0/10/0, bit-exact.
